instr_fetch: RTL and testbench

//  Fetch stage: producer side of the fetch->decode interface consumed by the decode stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/data_fetch_io.sv | 18 +
 rtl/fetch_skid_buffer.sv | 27 ++
 rtl/instr_fetch.sv | 155 +++++++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, bubble/halt encodings
// and the {instr, pc} entry carried by the skid buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/data_fetch_io.sv
// Fetch->decode bundle: valid, instr, pc, pc_plus4.
// Producer is the fetch stage, consumer is decode.
interface data_fetch_io;

    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport producer (
        output valid, instr, pc, pc_plus4
    );

    modport consumer (
        input valid, instr, pc, pc_plus4
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a returned BRAM word during a stall.
// Ports: clk, rst, load, clear (wins over load), din, valid, dout.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads a 1-cycle sync BRAM, feeds D.
// Ports: start/stall_d/redirect in, imem_en/addr out, D bundle + halted out.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_AW    = 14,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR,
    parameter logic [31:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall_d,
    input  logic               pc_src_e,
    input  logic [31:0]        pc_target_e,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               valid_d,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc_plus4_d,
    output logic               halted
);

    import fetch_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc_f;
    logic [31:0]  pc_if;
    logic         inflight;

    logic         run;
    logic         redirect;
    logic         d_load;
    logic         halt_load;
    logic         issue;
    logic [31:0]  fetch_pc;

    logic         skid_valid;
    logic         skid_load;
    logic         skid_clear;
    fetch_entry_t skid_q;
    fetch_entry_t ret_entry;
    fetch_entry_t src_entry;
    logic         src_valid;

    data_fetch_io d_io ();

    assign run      = (state == RUN);
    assign redirect = run & pc_src_e;
    assign d_load   = run & ~stall_d & ~redirect;

    // Skid content is older than the BRAM return, so it goes first.
    always_comb begin
        ret_entry.instr = imem_rdata;
        ret_entry.pc    = pc_if;
        src_valid       = skid_valid | inflight;
        src_entry       = skid_valid ? skid_q : ret_entry;
    end

    assign halt_load = d_load & src_valid
                     & (src_entry.instr == HALT_INSTR);

    // While stalled, one outstanding word is the most the
    // skid can absorb, so stop issuing once one is pending.
    assign issue = run & ~halt_load
                 & (redirect | ~stall_d | (~inflight & ~skid_valid));

    assign fetch_pc  = redirect ? pc_target_e : pc_f;
    assign imem_en   = issue;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    assign skid_load  = run & inflight & stall_d & ~redirect;
    assign skid_clear = redirect | halt_load | (d_load & skid_valid);

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (ret_entry),
        .valid (skid_valid),
        .dout  (skid_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            halted   <= 1'b0;
            pc_f     <= RESET_PC;
            pc_if    <= '0;
            inflight <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc_f  <= RESET_PC;
                    end
                end
                RUN: begin
                    if (halt_load) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        pc_f   <= RESET_PC;
                    end
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
            inflight <= issue;
            if (issue) begin
                pc_f  <= fetch_pc + 32'd4;
                pc_if <= fetch_pc;
            end
        end
    end

    // D register; a bubble keeps the old pc so only valid/instr move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_io.valid    <= 1'b0;
            d_io.instr    <= NOP_INSTR;
            d_io.pc       <= '0;
            d_io.pc_plus4 <= '0;
        end else if (redirect) begin
            d_io.valid <= 1'b0;
            d_io.instr <= NOP_INSTR;
        end else if (d_load) begin
            if (src_valid) begin
                d_io.valid    <= 1'b1;
                d_io.instr    <= src_entry.instr;
                d_io.pc       <= src_entry.pc;
                d_io.pc_plus4 <= src_entry.pc + 32'd4;
            end else begin
                d_io.valid <= 1'b0;
                d_io.instr <= NOP_INSTR;
            end
        end
    end

    assign valid_d    = d_io.valid;
    assign instr_d    = d_io.instr;
    assign pc_d       = d_io.pc;
    assign pc_plus4_d = d_io.pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector tables plus
// hand-written reset sequences around them.
module tb_instr_fetch;

    import fetch_pkg::*;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stall_d;
    logic          pc_src_e;
    logic [31:0]   pc_target_e;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          valid_d;
    logic [31:0]   instr_d;
    logic [31:0]   pc_d;
    logic [31:0]   pc_plus4_d;
    logic          halted;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks;
    int failures;

    typedef struct {
        logic        start;
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        en;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        halted;
    } vec_t;

    vec_t tv[$];

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall_d     (stall_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync BRAM model; poisoned data when no read was issued.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    function automatic vec_t mk(
        input logic st, input logic sl, input logic sr,
        input logic [31:0] tg, input logic en, input logic vd,
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] p4, input logic hl
    );
        vec_t v;
        v.start = st; v.stall = sl; v.src = sr; v.tgt = tg;
        v.en = en; v.valid = vd; v.instr = ins; v.pc = pc;
        v.p4 = p4; v.halted = hl;
        return v;
    endfunction

    task automatic chk(
        input string name, input int idx,
        input logic [127:0] act, input logic [127:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h",
                     name, idx, act, exp);
        end
    endtask

    function automatic logic [127:0] d_now();
        return {30'b0, valid_d, instr_d, pc_d, pc_plus4_d, halted};
    endfunction

    task automatic run_table(input string name);
        for (int i = 0; i < tv.size(); i++) begin
            start       = tv[i].start;
            stall_d     = tv[i].stall;
            pc_src_e    = tv[i].src;
            pc_target_e = tv[i].tgt;
            #1;
            chk({name, "_en"}, i, {127'b0, imem_en},
                {127'b0, tv[i].en});
            @(negedge clk);
            chk({name, "_d"}, i, d_now(),
                {30'b0, tv[i].valid, tv[i].instr, tv[i].pc,
                 tv[i].p4, tv[i].halted});
        end
        start    = 1'b0;
        stall_d  = 1'b0;
        pc_src_e = 1'b0;
        tv.delete();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_d"}, 0, d_now(),
            {30'b0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0});
        chk({name, "_en"}, 0, {127'b0, imem_en}, 128'b0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        stall_d     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'h0;
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = i * 4 + 32'h100;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Streaming, stall hold, redirect, redirect+stall, PC wrap.
        tv.push_back(mk(1,0,0,0, 0,0,NOP_INSTR,0,0,0));
        tv.push_back(mk(0,0,0,0, 1,0,NOP_INSTR,0,0,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h100,0,4,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h104,4,8,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h108,8,'hC,0));
        tv.push_back(mk(0,1,0,0, 0,1,'h108,8,'hC,0));
        tv.push_back(mk(0,1,0,0, 0,1,'h108,8,'hC,0));
        tv.push_back(mk(0,1,0,0, 0,1,'h108,8,'hC,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h10C,'hC,'h10,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h110,'h10,'h14,0));
        tv.push_back(mk(0,0,1,'h40, 1,0,NOP_INSTR,'h10,'h14,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h140,'h40,'h44,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h144,'h44,'h48,0));
        tv.push_back(mk(0,1,0,0, 0,1,'h144,'h44,'h48,0));
        tv.push_back(mk(0,1,1,'h40, 1,0,NOP_INSTR,'h44,'h48,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h140,'h40,'h44,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h144,'h44,'h48,0));
        tv.push_back(mk(0,0,1,'hFFFF_FFFC,
                        1,0,NOP_INSTR,'h44,'h48,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h100FC,'hFFFF_FFFC,0,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h100,0,4,0));
        run_table("stream");

        // Reset with a word in flight that lands in the skid.
        stall_d = 1'b1;
        #1;
        chk("stall_inflight_en", 0, {127'b0, imem_en}, 128'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        @(negedge clk);
        rst     = 1'b0;
        stall_d = 1'b0;
        tv.push_back(mk(1,0,0,0, 0,0,NOP_INSTR,0,0,0));
        tv.push_back(mk(0,0,0,0, 1,0,NOP_INSTR,0,0,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h100,0,4,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h104,4,8,0));
        run_table("restart");

        // Halt at 0x20, redirect ignored in HALT, restart from 0.
        mem[8] = HALT_INSTR;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tv.push_back(mk(1,0,0,0, 0,0,NOP_INSTR,0,0,0));
        tv.push_back(mk(0,0,0,0, 1,0,NOP_INSTR,0,0,0));
        for (int k = 0; k < 8; k++)
            tv.push_back(mk(0,0,0,0, 1,1, 32'h100 + k*4,
                            k*4, k*4 + 4, 0));
        tv.push_back(mk(0,0,0,0, 0,1,HALT_INSTR,'h20,'h24,1));
        tv.push_back(mk(0,0,1,'h80, 0,1,HALT_INSTR,'h20,'h24,1));
        tv.push_back(mk(0,1,0,0, 0,1,HALT_INSTR,'h20,'h24,1));
        tv.push_back(mk(1,0,0,0, 0,1,HALT_INSTR,'h20,'h24,0));
        tv.push_back(mk(0,0,0,0, 1,0,NOP_INSTR,'h20,'h24,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h100,0,4,0));
        tv.push_back(mk(0,0,0,0, 1,1,'h104,4,8,0));
        run_table("halt");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
